// File: rtl/hazard_forward_unit.sv
// hazard_forward_unit: scoreboard-based forwarding select, load-use stall, bubble and stall counter for the MIPS150 pipeline
//   clk, rst_n          clock and asynchronous active-low reset
//   id_*                decode-stage instruction: sources, their use flags, destination, load flag
//   ex_redirect         taken branch/jump this cycle; kills the decode instruction
//   fwd_sel_a/b         0 = register file, k = result of tracked stage k
//   stall               hold PC and IF/ID
//   bubble              stage 1 receives a NOP
//   stall_count         saturating count of stall cycles
module hazard_forward_unit #(
  parameter int REG_AW = 5,
  parameter int STAGES = 3,
  parameter int LOAD_STAGE = 2,
  parameter int SEL_W = 2,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_rs_used,
  input  logic              id_rt_used,
  input  logic              id_wr_en,
  input  logic [REG_AW-1:0] id_wr_reg,
  input  logic              id_is_load,
  input  logic              ex_redirect,
  output logic [SEL_W-1:0]  fwd_sel_a,
  output logic [SEL_W-1:0]  fwd_sel_b,
  output logic              stall,
  output logic              bubble,
  output logic [CNT_W-1:0]  stall_count
);
  logic [STAGES:1] v, ld;
  logic [REG_AW-1:0] wr [1:STAGES];
  logic [SEL_W-1:0] sa, sb;
  logic la, lb, ua, ub, stall_a, stall_b;
  // Scan oldest to youngest so the youngest match overwrites; la/lb flag a match too young to carry load data.
  always_comb begin
    sa = '0;
    sb = '0;
    la = 1'b0;
    lb = 1'b0;
    for (int k = STAGES; k >= 1; k--) begin
      if (v[k] && wr[k] == id_rs) begin
        sa = SEL_W'(k);
        la = ld[k] && (k < LOAD_STAGE);
      end
      if (v[k] && wr[k] == id_rt) begin
        sb = SEL_W'(k);
        lb = ld[k] && (k < LOAD_STAGE);
      end
    end
  end
  assign ua = id_valid && id_rs_used && (id_rs != '0);
  assign ub = id_valid && id_rt_used && (id_rt != '0);
  assign stall_a = ua && la;
  assign stall_b = ub && lb;
  assign fwd_sel_a = (ua && !la) ? sa : '0;
  assign fwd_sel_b = (ub && !lb) ? sb : '0;
  assign stall = (stall_a || stall_b) && !ex_redirect;
  assign bubble = stall || ex_redirect;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v <= '0;
      ld <= '0;
      for (int k = 1; k <= STAGES; k++) wr[k] <= '0;
      stall_count <= '0;
    end else begin
      for (int k = STAGES; k >= 2; k--) begin
        v[k] <= v[k-1];
        ld[k] <= ld[k-1];
        wr[k] <= wr[k-1];
      end
      v[1] <= id_valid && !bubble && id_wr_en && (id_wr_reg != '0);
      ld[1] <= id_is_load;
      wr[1] <= id_wr_reg;
      if (stall && stall_count != '1) stall_count <= stall_count + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_hazard_forward_unit.sv
// tb_hazard_forward_unit: vector table, hand sequences and randomized run against a queue-based reference model
module tb_hazard_forward_unit;
  localparam int STAGES = 3;
  localparam int LOAD_STAGE = 2;
  logic clk = 1'b0, rst_n = 1'b0;
  logic id_valid, id_rs_used, id_rt_used, id_wr_en, id_is_load, ex_redirect;
  logic [4:0] id_rs, id_rt, id_wr_reg;
  logic [1:0] fwd_sel_a, fwd_sel_b;
  logic stall, bubble;
  logic [15:0] stall_count;
  int n_cmp = 0, n_bad = 0;
  typedef struct {
    logic val; logic [4:0] rs, rt; logic rsu, rtu, we; logic [4:0] wr; logic ld, redir;
    int ea, eb, es, eu;
  } vec_t;
  typedef struct {logic v; logic [4:0] r; logic ld;} ent_t;
  vec_t tbl[18];
  ent_t q[$];
  int mcnt;
  hazard_forward_unit dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_wr_en(id_wr_en), .id_wr_reg(id_wr_reg),
    .id_is_load(id_is_load), .ex_redirect(ex_redirect), .fwd_sel_a(fwd_sel_a), .fwd_sel_b(fwd_sel_b),
    .stall(stall), .bubble(bubble), .stall_count(stall_count)
  );
  always #5 clk = ~clk;
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic drive(input vec_t t);
    id_valid = t.val; id_rs = t.rs; id_rt = t.rt; id_rs_used = t.rsu; id_rt_used = t.rtu;
    id_wr_en = t.we; id_wr_reg = t.wr; id_is_load = t.ld; ex_redirect = t.redir;
  endtask
  function automatic vec_t mk(input logic val, input int rs, input int rt, input logic rsu, input logic rtu,
                              input logic we, input int wr, input logic ld, input logic redir,
                              input int ea, input int eb, input int es, input int eu);
    vec_t t;
    t.val = val; t.rs = 5'(rs); t.rt = 5'(rt); t.rsu = rsu; t.rtu = rtu; t.we = we; t.wr = 5'(wr);
    t.ld = ld; t.redir = redir; t.ea = ea; t.eb = eb; t.es = es; t.eu = eu;
    return t;
  endfunction
  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    q = {};
    mcnt = 0;
  endtask
  // Reference: q[i] is the instruction issued i+1 cycles ago; a source looks for its youngest writer.
  function automatic void model_src(input logic used, input logic [4:0] s, output int sel, output logic st);
    sel = 0;
    st = 1'b0;
    if (!id_valid || !used || s == 0) return;
    foreach (q[i]) if (q[i].v && q[i].r == s) begin
      if (q[i].ld && i + 1 < LOAD_STAGE) st = 1'b1;
      else sel = i + 1;
      return;
    end
  endfunction
  initial begin
    vec_t t;
    ent_t e;
    int sa, sb, es, eu;
    logic lsa, lsb;
    tbl[0]  = mk(1, 5, 6, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[1]  = mk(1, 1, 2, 1, 1, 1, 3, 0, 0, 0, 0, 0, 0);
    tbl[2]  = mk(1, 3, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    tbl[3]  = mk(1, 3, 0, 1, 0, 0, 0, 0, 0, 2, 0, 0, 0);
    tbl[4]  = mk(1, 3, 0, 1, 0, 0, 0, 0, 0, 3, 0, 0, 0);
    tbl[5]  = mk(1, 3, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[6]  = mk(1, 1, 0, 1, 0, 1, 4, 1, 0, 0, 0, 0, 0);
    tbl[7]  = mk(1, 0, 4, 1, 1, 0, 0, 0, 0, 0, 0, 1, 1);
    tbl[8]  = mk(1, 0, 4, 1, 1, 0, 0, 0, 0, 0, 2, 0, 0);
    tbl[9]  = mk(1, 1, 2, 1, 1, 1, 7, 0, 0, 0, 0, 0, 0);
    tbl[10] = mk(1, 0, 0, 0, 0, 1, 7, 0, 0, 0, 0, 0, 0);
    tbl[11] = mk(1, 7, 7, 1, 1, 0, 0, 0, 0, 1, 1, 0, 0);
    tbl[12] = mk(1, 1, 2, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    tbl[13] = mk(1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[14] = mk(1, 1, 2, 1, 1, 1, 8, 0, 0, 0, 0, 0, 0);
    tbl[15] = mk(1, 0, 8, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[16] = mk(1, 0, 8, 0, 1, 0, 0, 0, 0, 0, 2, 0, 0);
    tbl[17] = mk(0, 8, 8, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    do_reset();
    @(negedge clk);
    chk("reset_count", int'(stall_count), 0);
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      drive(tbl[i]);
      #1;
      chk($sformatf("v%0d_sel_a", i), int'(fwd_sel_a), tbl[i].ea);
      chk($sformatf("v%0d_sel_b", i), int'(fwd_sel_b), tbl[i].eb);
      chk($sformatf("v%0d_stall", i), int'(stall), tbl[i].es);
      chk($sformatf("v%0d_bubble", i), int'(bubble), tbl[i].eu);
    end
    @(negedge clk);
    chk("loaduse_count", int'(stall_count), 1);
    // Redirect over a load-use: no stall, bubble forced, counter unchanged.
    drive(mk(1, 1, 0, 1, 0, 1, 2, 1, 0, 0, 0, 0, 0));
    @(negedge clk);
    drive(mk(1, 2, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    #1;
    chk("redir_stall", int'(stall), 0);
    chk("redir_bubble", int'(bubble), 1);
    @(negedge clk);
    chk("redir_count", int'(stall_count), 1);
    drive(mk(1, 2, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    #1;
    chk("redir_killed_sel", int'(fwd_sel_a), 2);
    // Reset in the middle of a pending load-use.
    @(negedge clk);
    drive(mk(1, 1, 0, 1, 0, 1, 9, 1, 0, 0, 0, 0, 0));
    @(negedge clk);
    drive(mk(1, 9, 9, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    #1;
    chk("pre_rst_stall", int'(stall), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_stall", int'(stall), 0);
    chk("rst_bubble", int'(bubble), 0);
    chk("rst_count", int'(stall_count), 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    #1;
    chk("rst_sel_a", int'(fwd_sel_a), 0);
    chk("rst_sel_b", int'(fwd_sel_b), 0);
    // Randomized run against the reference model.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      t.val = ($urandom_range(0, 9) != 0);
      t.rs = 5'($urandom_range(0, 6));
      t.rt = 5'($urandom_range(0, 6));
      t.rsu = 1'($urandom);
      t.rtu = 1'($urandom);
      t.we = ($urandom_range(0, 3) != 0);
      t.wr = 5'($urandom_range(0, 6));
      t.ld = ($urandom_range(0, 2) == 0);
      t.redir = ($urandom_range(0, 7) == 0);
      drive(t);
      #1;
      model_src(t.rsu, t.rs, sa, lsa);
      model_src(t.rtu, t.rt, sb, lsb);
      es = (lsa || lsb) && !t.redir;
      eu = es || t.redir;
      chk("rnd_sel_a", int'(fwd_sel_a), sa);
      chk("rnd_sel_b", int'(fwd_sel_b), sb);
      chk("rnd_stall", int'(stall), es);
      chk("rnd_bubble", int'(bubble), eu);
      chk("rnd_count", int'(stall_count), mcnt);
      e.v = t.val && !eu && t.we && t.wr != 0;
      e.r = t.wr;
      e.ld = t.ld;
      q.push_front(e);
      if (q.size() > STAGES) void'(q.pop_back());
      if (es && mcnt < 65535) mcnt++;
    end
    @(negedge clk);
    chk("rnd_final_count", int'(stall_count), mcnt);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
